// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control width, forwarding-select encoding, address width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Width of the opaque decoded-control bundle carried alongside operands.
    localparam int CTRL_W = 8;

    // Operand source chosen by a forwarding selector, lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_WB  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_EX  = 2'd3
    } fwd_sel_e;

    // Register-index width for a register file of the given depth (never below 1).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand source selector: picks EX/MEM/WB/regfile data and flags a hazard that must stall.
// Latency: purely combinational.
// Backpressure: none itself; hazard feeds the stage's stall output.
//
// Ports: rs/use_rs (operand index and whether it is actually read), ex_*/mem_*/wb_* bypass
// sources, rf_dout (register-file read data), operand (selected value), hazard (must stall).
// Build option OPERAND_STAGE_FWD_EN: when defined, bypass muxes are built and only a load in
// EX stalls; otherwise operands come from the register file and any in-flight EX/MEM write
// to a used operand stalls.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int Width = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]    rs,
    input  logic             use_rs,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [AW-1:0]    ex_rd,
    input  logic [Width-1:0] ex_res,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_rd,
    input  logic [Width-1:0] mem_res,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_rd,
    input  logic [Width-1:0] wb_data,
    input  logic [Width-1:0] rf_dout,
    output logic [Width-1:0] operand,
    output logic             hazard
);

    // x0 is hardwired to zero: it never matches a producer and always reads as 0.
    logic rs_nz;
    logic ex_hit;
    logic mem_hit;

    assign rs_nz   = |rs;
    assign ex_hit  = ex_we  && (ex_rd  == rs) && rs_nz;
    assign mem_hit = mem_we && (mem_rd == rs) && rs_nz;

`ifdef OPERAND_STAGE_FWD_EN

    logic     wb_hit;
    fwd_sel_e sel;

    assign wb_hit = wb_we && (wb_rd == rs) && rs_nz;

    // Youngest producer wins.
    always_comb begin
        sel = SEL_RF;
        if (ex_hit)       sel = SEL_EX;
        else if (mem_hit) sel = SEL_MEM;
        else if (wb_hit)  sel = SEL_WB;
    end

    always_comb begin
        operand = '0;
        if (rs_nz) begin
            case (sel)
                SEL_EX:  operand = ex_res;
                SEL_MEM: operand = mem_res;
                SEL_WB:  operand = wb_data;
                default: operand = rf_dout;
            endcase
        end
    end

    // Load data is not available until MEM, so only a load in EX must wait.
    assign hazard = use_rs && ex_hit && ex_load;

`else

    // No bypass paths: wait until the producer has retired into the register file.
    // WB writes are visible through the register file read, so WB never stalls.
    assign operand = rs_nz ? rf_dout : '0;
    assign hazard  = use_rs && (ex_hit || mem_hit);

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_load, ex_res, mem_res, wb_we, wb_rd, wb_data};

`endif

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: reads the register pair, resolves bypasses/hazards, registers operands.
// Latency: one cycle from in_valid to out_valid.
// Backpressure: stall (combinational) holds upstream on a hazard or hold; hazards insert a bubble.
//
// Ports: clk, reset (synchronous, active-high); in_* decoded instruction; rf_addr*/rf_dout*
// register-file read pair; ex_*/mem_*/wb_* bypass sources; flush, hold; stall; out_* registered
// operand bundle.
// Build option OPERAND_STAGE_FWD_EN: enables EX/MEM/WB forwarding (see fwd_select).
module operand_stage
    import pipe_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 32,
    localparam int AW   = addr_width(Depth)
) (
    input  logic              clk,
    input  logic              reset,
    // decoded instruction
    input  logic              in_valid,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [Width-1:0]  in_pc,
    input  logic [Width-1:0]  in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    // register-file read pair
    output logic [AW-1:0]     rf_addr0,
    output logic [AW-1:0]     rf_addr1,
    input  logic [Width-1:0]  rf_dout0,
    input  logic [Width-1:0]  rf_dout1,
    // bypass sources
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [AW-1:0]     ex_rd,
    input  logic [Width-1:0]  ex_res,
    input  logic              mem_we,
    input  logic [AW-1:0]     mem_rd,
    input  logic [Width-1:0]  mem_res,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rd,
    input  logic [Width-1:0]  wb_data,
    // pipeline control
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    // registered operand bundle
    output logic              out_valid,
    output logic [Width-1:0]  out_a,
    output logic [Width-1:0]  out_b,
    output logic [Width-1:0]  out_pc,
    output logic [Width-1:0]  out_imm,
    output logic [AW-1:0]     out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic [Width-1:0] op_a;
    logic [Width-1:0] op_b;
    logic             haz_a;
    logic             haz_b;
    logic             data_hazard;

    // Register read addresses come straight from decode so data is ready at the next edge.
    assign rf_addr0 = in_rs1;
    assign rf_addr1 = in_rs2;

    fwd_select #(.Width(Width), .AW(AW)) u_fwd_a (
        .rs      (in_rs1),
        .use_rs  (in_use1),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .ex_res  (ex_res),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd),
        .mem_res (mem_res),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_dout (rf_dout0),
        .operand (op_a),
        .hazard  (haz_a)
    );

    fwd_select #(.Width(Width), .AW(AW)) u_fwd_b (
        .rs      (in_rs2),
        .use_rs  (in_use2),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .ex_res  (ex_res),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd),
        .mem_res (mem_res),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_dout (rf_dout1),
        .operand (op_b),
        .hazard  (haz_b)
    );

    // A hazard only matters for a real instruction.
    assign data_hazard = in_valid && (haz_a || haz_b);

    // Reset and flush both win over everything; an empty slot never asks upstream to wait.
    assign stall = !reset && !flush && in_valid && (hold || data_hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_rd    <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            // Data fields left as-is; they are meaningless once out_valid drops.
            out_valid <= 1'b0;
        end else if (hold) begin
            // Downstream is not consuming: freeze the whole bundle.
            out_valid <= out_valid;
        end else if (data_hazard) begin
            // Insert a bubble; the instruction is retried while upstream holds in_*.
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_a     <= op_a;
            out_b     <= op_b;
            out_pc    <= in_pc;
            out_imm   <= in_imm;
            out_rd    <= in_rd;
            out_ctrl  <= in_ctrl;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_use1, in_use2;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [W-1:0]  in_pc, in_imm;
    logic [7:0]    in_ctrl;
    logic [AW-1:0] rf_addr0, rf_addr1;
    logic [W-1:0]  rf_dout0, rf_dout1;
    logic          ex_we, ex_load, mem_we, wb_we;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [W-1:0]  ex_res, mem_res, wb_data;
    logic          flush, hold, stall, out_valid;
    logic [W-1:0]  out_a, out_b, out_pc, out_imm;
    logic [AW-1:0] out_rd;
    logic [7:0]    out_ctrl;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    operand_stage #(.Width(W), .Depth(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use1(in_use1), .in_use2(in_use2), .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_dout0(rf_dout0), .rf_dout1(rf_dout1),
        .ex_we(ex_we), .ex_load(ex_load), .ex_rd(ex_rd), .ex_res(ex_res),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_res(mem_res),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .hold(hold), .stall(stall),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_pc(out_pc),
        .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    // Advance one clock; inputs and samples live 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_use1 = 0; in_use2 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_pc = 0; in_imm = 0; in_ctrl = 0;
        rf_dout0 = 0; rf_dout1 = 0;
        ex_we = 0; ex_load = 0; ex_rd = 0; ex_res = 0;
        mem_we = 0; mem_rd = 0; mem_res = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; hold = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        in_valid = 1; in_rs1 = 7; in_use1 = 1; in_rd = 3; in_pc = 32'h123;
        in_imm = 32'h456; in_ctrl = 8'h5A; rf_dout0 = 32'hDEAD; rf_dout1 = 32'hBEEF;
        ex_we = 1; ex_load = 1; ex_rd = 7; hold = 1;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_a !== 32'h0) begin fails++; $display("FAIL reset_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin fails++; $display("FAIL reset_b got %h want 0", out_b); end
        checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", out_pc); end
        checks++; if (out_imm !== 32'h0) begin fails++; $display("FAIL reset_imm got %h want 0", out_imm); end
        checks++; if (out_rd !== 5'h0) begin fails++; $display("FAIL reset_rd got %h want 0", out_rd); end
        checks++; if (out_ctrl !== 8'h0) begin fails++; $display("FAIL reset_ctrl got %h want 0", out_ctrl); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall2 got %b want 0", stall); end
        reset = 0;
        idle();
        step();
    endtask

    task automatic test_rf_addr();
        idle();
        in_rs1 = 9; in_rs2 = 17;
        #1;
        checks++; if (rf_addr0 !== 5'd9) begin fails++; $display("FAIL rf_addr0 got %0d want 9", rf_addr0); end
        checks++; if (rf_addr1 !== 5'd17) begin fails++; $display("FAIL rf_addr1 got %0d want 17", rf_addr1); end
    endtask

    task automatic test_passthrough();
        idle();
        in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_use1 = 1; in_use2 = 1;
        rf_dout0 = 32'h1234; rf_dout1 = 32'h5678;
        in_pc = 32'h100; in_imm = 32'hFFFF_FFF0; in_rd = 4; in_ctrl = 8'hA5;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL pass_stall got %b want 0", stall); end
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid got %b want 1", out_valid); end
        checks++; if (out_a !== 32'h1234) begin fails++; $display("FAIL pass_a got %h want 1234", out_a); end
        checks++; if (out_b !== 32'h5678) begin fails++; $display("FAIL pass_b got %h want 5678", out_b); end
        checks++; if (out_pc !== 32'h100) begin fails++; $display("FAIL pass_pc got %h want 100", out_pc); end
        checks++; if (out_imm !== 32'hFFFF_FFF0) begin fails++; $display("FAIL pass_imm got %h want fffffff0", out_imm); end
        checks++; if (out_rd !== 5'd4) begin fails++; $display("FAIL pass_rd got %0d want 4", out_rd); end
        checks++; if (out_ctrl !== 8'hA5) begin fails++; $display("FAIL pass_ctrl got %h want a5", out_ctrl); end
    endtask

    task automatic test_ex_fwd();
        idle();
        in_valid = 1; in_rs1 = 5; in_use1 = 1; rf_dout0 = 32'h99;
        ex_we = 1; ex_rd = 5; ex_res = 32'h11;
        #1;
`ifdef OPERAND_STAGE_FWD_EN
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL exfwd_stall got %b want 0", stall); end
        step();
`else
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL exdep_stall got %b want 1", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL exdep_bubble got %b want 0", out_valid); end
        // Producer retired into the register file.
        ex_we = 0; rf_dout0 = 32'h11;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL exdep_release got %b want 0", stall); end
        step();
`endif
        checks++; if (out_a !== 32'h11) begin fails++; $display("FAIL exfwd_a got %h want 11", out_a); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL exfwd_valid got %b want 1", out_valid); end
    endtask

    task automatic test_priority();
        idle();
        in_valid = 1; in_rs2 = 3; in_use2 = 1; rf_dout1 = 32'hC;
        ex_we = 1; ex_rd = 3; ex_res = 32'hA;
        mem_we = 1; mem_rd = 3; mem_res = 32'hB;
        #1;
`ifdef OPERAND_STAGE_FWD_EN
        step();
        checks++; if (out_b !== 32'hA) begin fails++; $display("FAIL prio_b got %h want a", out_b); end
`else
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL prio_stall got %b want 1", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL prio_bubble got %b want 0", out_valid); end
        // EX retired, MEM still pending: keep waiting.
        ex_we = 0;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL prio_memstall got %b want 1", stall); end
`endif
    endtask

    task automatic test_wb();
        idle();
        in_valid = 1; in_rs1 = 6; in_use1 = 1; rf_dout0 = 32'h55;
        wb_we = 1; wb_rd = 6; wb_data = 32'h66;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL wb_stall got %b want 0", stall); end
        step();
`ifdef OPERAND_STAGE_FWD_EN
        checks++; if (out_a !== 32'h66) begin fails++; $display("FAIL wb_a got %h want 66", out_a); end
`else
        checks++; if (out_a !== 32'h55) begin fails++; $display("FAIL wb_a got %h want 55", out_a); end
`endif
    endtask

    task automatic test_load_use();
        idle();
        in_valid = 1; in_rs1 = 7; in_use1 = 1; rf_dout0 = 32'h99; in_pc = 32'h40;
        ex_we = 1; ex_load = 1; ex_rd = 7; ex_res = 32'hEE;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %b want 0", out_valid); end
        // Load moves to MEM.
        ex_we = 0; ex_load = 0; mem_we = 1; mem_rd = 7; mem_res = 32'h42;
        #1;
`ifdef OPERAND_STAGE_FWD_EN
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_release got %b want 0", stall); end
        step();
`else
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_memstall got %b want 1", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble2 got %b want 0", out_valid); end
        mem_we = 0; rf_dout0 = 32'h42;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_release got %b want 0", stall); end
        step();
`endif
        checks++; if (out_a !== 32'h42) begin fails++; $display("FAIL lu_a got %h want 42", out_a); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lu_valid got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h40) begin fails++; $display("FAIL lu_pc got %h want 40", out_pc); end
    endtask

    task automatic test_use_gate();
        idle();
        in_valid = 1; in_rs2 = 8; in_use2 = 0; rf_dout1 = 32'h88;
        ex_we = 1; ex_load = 1; ex_rd = 8; ex_res = 32'h77;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL use_stall got %b want 0", stall); end
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL use_valid got %b want 1", out_valid); end
    endtask

    task automatic test_x0();
        idle();
        in_valid = 1; in_rs1 = 0; in_use1 = 1; rf_dout0 = 32'h77;
        ex_we = 1; ex_rd = 0; ex_res = 32'hFF;
        mem_we = 1; mem_rd = 0; mem_res = 32'hF0;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall got %b want 0", stall); end
        step();
        checks++; if (out_a !== 32'h0) begin fails++; $display("FAIL x0_a got %h want 0", out_a); end
    endtask

    task automatic test_invalid();
        idle();
        in_valid = 0; in_rs1 = 7; in_use1 = 1;
        ex_we = 1; ex_load = 1; ex_rd = 7;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL inv_stall got %b want 0", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inv_valid got %b want 0", out_valid); end
    endtask

    task automatic test_hold();
        idle();
        in_valid = 1; in_rs1 = 1; in_use1 = 1; rf_dout0 = 32'h1; in_pc = 32'h200;
        step();
        checks++; if (out_a !== 32'h1) begin fails++; $display("FAIL hold_pre_a got %h want 1", out_a); end
        hold = 1; in_pc = 32'h300; rf_dout0 = 32'h2;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_stall got %b want 1", stall); end
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid got %b want 1", out_valid); end
        checks++; if (out_a !== 32'h1) begin fails++; $display("FAIL hold_a got %h want 1", out_a); end
        checks++; if (out_pc !== 32'h200) begin fails++; $display("FAIL hold_pc got %h want 200", out_pc); end
        hold = 0;
        step();
        checks++; if (out_pc !== 32'h300) begin fails++; $display("FAIL hold_rel_pc got %h want 300", out_pc); end
        checks++; if (out_a !== 32'h2) begin fails++; $display("FAIL hold_rel_a got %h want 2", out_a); end
    endtask

    task automatic test_flush_hold();
        idle();
        in_valid = 1; in_rs1 = 1; rf_dout0 = 32'h3;
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_pre got %b want 1", out_valid); end
        hold = 1; flush = 1;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall got %b want 0", stall); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        idle();
        in_valid = 1; in_rs1 = 2; rf_dout0 = 32'hA1; in_pc = 32'h10; in_ctrl = 8'h11;
        step();
        checks++; if (out_pc !== 32'h10) begin fails++; $display("FAIL b2b_pc0 got %h want 10", out_pc); end
        checks++; if (out_a !== 32'hA1) begin fails++; $display("FAIL b2b_a0 got %h want a1", out_a); end
        in_pc = 32'h14; rf_dout0 = 32'hB2; in_ctrl = 8'h3C;
        step();
        checks++; if (out_pc !== 32'h14) begin fails++; $display("FAIL b2b_pc1 got %h want 14", out_pc); end
        checks++; if (out_a !== 32'hB2) begin fails++; $display("FAIL b2b_a1 got %h want b2", out_a); end
        checks++; if (out_ctrl !== 8'h3C) begin fails++; $display("FAIL b2b_ctrl got %h want 3c", out_ctrl); end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_rf_addr();
        test_passthrough();
        test_ex_fwd();
        test_priority();
        test_wb();
        test_load_use();
        test_use_gate();
        test_x0();
        test_invalid();
        test_hold();
        test_flush_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter Width, default 32, data/PC/immediate width.
REQ-002 SHALL have parameter Depth, default 32, register count; AW = $clog2(Depth).
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on posedge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports in_valid, in_rs1, in_rs2, in_rd, in_use1, in_use2, in_pc, in_imm, in_ctrl: input, 1/AW/AW/AW/1/1/Width/Width/8; decoded instruction from decode.
REQ-006 SHALL have ports rf_addr0, rf_addr1 (output, AW) and rf_dout0, rf_dout1 (input, Width); register-file read pair, data valid by the next posedge.
REQ-007 SHALL have ports ex_we, ex_load, ex_rd, ex_res; mem_we, mem_rd, mem_res; wb_we, wb_rd, wb_data: input, 1/1/AW/Width etc.; forwarding sources.
REQ-008 SHALL have inputs flush and hold (1 each); outputs stall (1), out_valid (1), out_a, out_b, out_pc, out_imm (Width), out_rd (AW), out_ctrl (8).

Function
REQ-009 SHALL drive rf_addr0 = in_rs1 and rf_addr1 = in_rs2 combinationally.
REQ-010 SHALL capture operands into the output register at posedge: one-cycle latency from in_valid to out_valid.
REQ-011 SHALL select each operand with priority EX > MEM > WB > rf_dout, a source matching only when its we=1, its rd equals the rs field, and the rs field is nonzero.
REQ-012 SHALL never forward for rs = 0; operand for x0 is always 0.
REQ-013 SHALL treat an EX match with ex_load=1 as load-use: stall=1 combinationally, output register loads a bubble (out_valid=0), in_* held by upstream.
REQ-014 SHALL only raise a hazard for rs1 when in_use1=1 and for rs2 when in_use2=1.
REQ-015 SHALL, when hold=1 and flush=0, keep all out_* unchanged and assert stall.
REQ-016 SHALL, when flush=1, set out_valid=0 next posedge regardless of hold/stall; out_* data don't-care; flush clears stall for that cycle.
REQ-017 SHALL deassert stall in the cycle after the load leaves EX; the retried instruction then takes the MEM-forwarded value.
REQ-018 SHALL pass in_pc, in_imm, in_rd, in_ctrl unchanged to out_* alongside operands.
REQ-019 SHALL produce stall=0 whenever in_valid=0.

Reset
REQ-020 SHALL on reset=1 at posedge set out_valid=0 and out_a, out_b, out_pc, out_imm, out_rd, out_ctrl to 0.
REQ-021 SHALL let reset override flush, hold and stall; stall output is 0 while reset=1.

Configuration
REQ-022 SHALL compile forwarding in when OPERAND_STAGE_FWD_EN is defined: behaviour per REQ-011..REQ-017.
REQ-023 SHALL, without OPERAND_STAGE_FWD_EN, omit forwarding muxes and stall on any used-operand match against EX or MEM (we=1, rd nonzero), operands taken from rf_dout only; WB data is visible through the register file.

Structure
REQ-024 SHALL take AW-derived widths, ctrl field width (8) and forwarding-select encoding (SEL_RF, SEL_WB, SEL_MEM, SEL_EX) from a shared package pipe_pkg.
REQ-025 SHALL instantiate one sub-module fwd_select per operand (combinational priority selector plus hazard flag).

Verification
REQ-026 SHALL test: reset=1 one cycle -> all out_* = 0, stall=0.
REQ-027 SHALL test: ex_we=1, ex_rd=5, ex_res=0x11, in_rs1=5, rf_dout0=0x99 -> out_a=0x11 next cycle.
REQ-028 SHALL test: ex_we=1 rd=3 res=0xA, mem_we=1 rd=3 res=0xB, in_rs2=3 -> out_b=0xA.
REQ-029 SHALL test: ex_load=1, ex_rd=7, in_rs1=7, in_use1=1 -> stall=1, out_valid=0; next cycle mem_rd=7 mem_res=0x42 -> out_a=0x42, out_valid=1.
REQ-030 SHALL test: in_rs1=0, ex_we=1, ex_rd=0, ex_res=0xFF -> out_a=0.
REQ-031 SHALL test: flush=1 together with hold=1 -> out_valid=0 next cycle.
